// File: rtl/snake_pkg.sv
// Shared definitions for the snake body: coordinate width, direction codes,
// controller state encoding and the packed cell helper.
package snake_pkg;

    localparam int COORD_W = 7;
    localparam int CELL_W  = 2 * COORD_W;

    localparam logic [1:0] WAY_UP    = 2'd0;
    localparam logic [1:0] WAY_DOWN  = 2'd1;
    localparam logic [1:0] WAY_RIGHT = 2'd2;
    localparam logic [1:0] WAY_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_CHECK    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    function automatic logic [CELL_W-1:0] pack_cell(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/snake_seg_shift.sv
// Segment store: shift register of packed (x,y) cells with a reset-pattern load,
// one indexed read port and a length-masked occupancy compare.
module snake_seg_shift
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int START_X = 24,
    parameter int START_Y = 32,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Init,
    input  logic              i_Shift,
    input  logic [CELL_W-1:0] i_Head,
    input  logic [IDX_W-1:0]  i_Rd_Idx,
    output logic [CELL_W-1:0] o_Rd,
    input  logic [IDX_W:0]    i_Len,
    input  logic [CELL_W-1:0] i_Q,
    output logic              o_Q_Hit
);

    logic [CELL_W-1:0] r_Seg [MAX_LEN];
    logic              w_Hit;

    // Body laid out leftwards from the start cell; cells past the live length are don't-care.
    function automatic logic [CELL_W-1:0] init_cell(input int k);
        return pack_cell(COORD_W'(START_X), COORD_W'(START_Y - k));
    endfunction

    // Segment storage: reset pattern on reset/restart, one-step shift on commit.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            for (int k = 0; k < MAX_LEN; k++) r_Seg[k] <= init_cell(k);
        end else if (i_Init) begin
            for (int k = 0; k < MAX_LEN; k++) r_Seg[k] <= init_cell(k);
        end else if (i_Shift) begin
            r_Seg[0] <= i_Head;
            for (int k = 1; k < MAX_LEN; k++) r_Seg[k] <= r_Seg[k-1];
        end
    end

    assign o_Rd = r_Seg[i_Rd_Idx];

    // Occupancy query, counting only the live segments.
    always_comb begin
        w_Hit = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            w_Hit = w_Hit | (((IDX_W+1)'(k) < i_Len) && (r_Seg[k] == i_Q));
        end
    end

    assign o_Q_Hit = w_Hit;

endmodule

// File: rtl/snake_body.sv
// Snake state holder: registers head/direction, scans the body one segment per
// cycle for self-collision after a wall test, then commits the move (with growth).
module snake_body
    import snake_pkg::*;
#(
    parameter int         MAX_LEN   = 16,
    parameter int         INIT_LEN  = 3,
    parameter int         ROWS      = 48,
    parameter int         COLS      = 64,
    parameter int         START_X   = 24,
    parameter int         START_Y   = 32,
    parameter logic [1:0] START_WAY = WAY_RIGHT
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Tick,
    input  logic [6:0]   i_Next_x,
    input  logic [6:0]   i_Next_y,
    input  logic [1:0]   i_Next_Way,
    input  logic [6:0]   i_Food_x,
    input  logic [6:0]   i_Food_y,
    input  logic         i_Restart,
    input  logic [6:0]   i_Q_x,
    input  logic [6:0]   i_Q_y,
    output logic [6:0]   o_Head_x,
    output logic [6:0]   o_Head_y,
    output logic [1:0]   o_Way,
    output logic [4:0]   o_Len,
    output logic         o_Eat,
    output logic         o_Busy,
    output logic         o_Game_Over,
    output logic         o_Q_Hit
);

    localparam int IDX_W = $clog2(MAX_LEN);

    state_t            r_State;
    logic [6:0]        r_Cand_x, r_Cand_y;
    logic [1:0]        r_Cand_Way;
    logic              r_Cand_Eat;
    logic [IDX_W-1:0]  r_Idx;
    logic [4:0]        r_Lim;
    logic [6:0]        r_Head_x, r_Head_y;
    logic [1:0]        r_Way;
    logic [4:0]        r_Len;
    logic              r_Eat, r_Busy, r_Game_Over;

    logic              w_Wall, w_Next_Eat, w_Seg_Hit, w_Last, w_Shift, w_Init;
    logic [4:0]        w_Lim;
    logic [CELL_W-1:0] w_Rd;

    // Out-of-range coordinates (including 0-1 wrapping to 127) are walls.
    assign w_Wall     = (i_Next_x >= 7'(ROWS)) || (i_Next_y >= 7'(COLS));
    assign w_Next_Eat = (i_Next_x == i_Food_x) && (i_Next_y == i_Food_y);
    // The tail vacates on a plain move, so it is excluded from the scan unless the body grows or is full.
    assign w_Lim      = (w_Next_Eat || (r_Len == 5'(MAX_LEN))) ? r_Len : (r_Len - 5'd1);
    assign w_Seg_Hit  = (w_Rd == pack_cell(r_Cand_x, r_Cand_y));
    assign w_Last     = (5'(r_Idx) == (r_Lim - 5'd1));
    assign w_Shift    = (r_State == ST_COMMIT);
    assign w_Init     = (r_State == ST_GAMEOVER) && i_Restart;

    snake_seg_shift #(
        .MAX_LEN (MAX_LEN),
        .START_X (START_X),
        .START_Y (START_Y),
        .IDX_W   (IDX_W)
    ) u_seg (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Init   (w_Init),
        .i_Shift  (w_Shift),
        .i_Head   (pack_cell(r_Cand_x, r_Cand_y)),
        .i_Rd_Idx (r_Idx),
        .o_Rd     (w_Rd),
        .i_Len    (r_Len),
        .i_Q      (pack_cell(i_Q_x, i_Q_y)),
        .o_Q_Hit  (o_Q_Hit)
    );

    // Move controller: RUN -> CHECK (scan) -> COMMIT, or GAMEOVER on wall/body hit.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State     <= ST_RUN;
            r_Cand_x    <= 7'd0;
            r_Cand_y    <= 7'd0;
            r_Cand_Way  <= 2'd0;
            r_Cand_Eat  <= 1'b0;
            r_Idx       <= {IDX_W{1'b0}};
            r_Lim       <= 5'd0;
            r_Head_x    <= 7'(START_X);
            r_Head_y    <= 7'(START_Y);
            r_Way       <= START_WAY;
            r_Len       <= 5'(INIT_LEN);
            r_Eat       <= 1'b0;
            r_Busy      <= 1'b0;
            r_Game_Over <= 1'b0;
        end else begin
            r_Eat <= 1'b0;
            case (r_State)
                ST_RUN: begin
                    if (i_Tick) begin
                        r_Cand_x   <= i_Next_x;
                        r_Cand_y   <= i_Next_y;
                        r_Cand_Way <= i_Next_Way;
                        r_Cand_Eat <= w_Next_Eat;
                        r_Lim      <= w_Lim;
                        r_Idx      <= {IDX_W{1'b0}};
                        if (w_Wall) begin
                            r_State     <= ST_GAMEOVER;
                            r_Game_Over <= 1'b1;
                        end else begin
                            r_State <= ST_CHECK;
                            r_Busy  <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_Seg_Hit) begin
                        r_State     <= ST_GAMEOVER;
                        r_Busy      <= 1'b0;
                        r_Game_Over <= 1'b1;
                    end else if (w_Last) begin
                        r_State <= ST_COMMIT;
                    end else begin
                        r_Idx <= r_Idx + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_COMMIT: begin
                    r_Head_x <= r_Cand_x;
                    r_Head_y <= r_Cand_y;
                    r_Way    <= r_Cand_Way;
                    if (r_Cand_Eat) begin
                        r_Eat <= 1'b1;
                        if (r_Len != 5'(MAX_LEN)) r_Len <= r_Len + 5'd1;
                    end
                    r_Busy  <= 1'b0;
                    r_State <= ST_RUN;
                end
                ST_GAMEOVER: begin
                    if (i_Restart) begin
                        r_State     <= ST_RUN;
                        r_Head_x    <= 7'(START_X);
                        r_Head_y    <= 7'(START_Y);
                        r_Way       <= START_WAY;
                        r_Len       <= 5'(INIT_LEN);
                        r_Busy      <= 1'b0;
                        r_Game_Over <= 1'b0;
                    end
                end
                default: begin
                    r_State     <= ST_RUN;
                    r_Busy      <= 1'b0;
                    r_Game_Over <= 1'b0;
                end
            endcase
        end
    end

    assign o_Head_x    = r_Head_x;
    assign o_Head_y    = r_Head_y;
    assign o_Way       = r_Way;
    assign o_Len       = r_Len;
    assign o_Eat       = r_Eat;
    assign o_Busy      = r_Busy;
    assign o_Game_Over = r_Game_Over;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: a reference model predicts each move's outcome
// and latency; predictions are queued on stimulus and popped when the move resolves.
module tb_snake_body;

    logic       i_Clk = 1'b0;
    logic       i_Rst, i_Tick, i_Restart;
    logic [6:0] i_Next_x, i_Next_y, i_Food_x, i_Food_y, i_Q_x, i_Q_y;
    logic [1:0] i_Next_Way;
    logic [6:0] o_Head_x, o_Head_y;
    logic [1:0] o_Way;
    logic [4:0] o_Len;
    logic       o_Eat, o_Busy, o_Game_Over, o_Q_Hit;

    snake_body dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Tick(i_Tick),
        .i_Next_x(i_Next_x), .i_Next_y(i_Next_y), .i_Next_Way(i_Next_Way),
        .i_Food_x(i_Food_x), .i_Food_y(i_Food_y), .i_Restart(i_Restart),
        .i_Q_x(i_Q_x), .i_Q_y(i_Q_y),
        .o_Head_x(o_Head_x), .o_Head_y(o_Head_y), .o_Way(o_Way), .o_Len(o_Len),
        .o_Eat(o_Eat), .o_Busy(o_Busy), .o_Game_Over(o_Game_Over), .o_Q_Hit(o_Q_Hit)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        int go;
        int busy0;
        int hx;
        int hy;
        int way;
        int len;
        int lat;
        int eats;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    int mx[16];
    int my[16];
    int mlen, mway, mgo;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mlen = 3;
        mway = 2;
        mgo  = 0;
        for (int k = 0; k < 16; k++) begin
            mx[k] = 24;
            my[k] = 32 - k;
        end
    endtask

    function automatic int model_hit(input int x, input int y);
        int h;
        h = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < mlen && mx[k] == x && my[k] == y) h = 1;
        end
        return h;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, "_hx"},  32'(o_Head_x),    32'(mx[0]));
        check_eq({tag, "_hy"},  32'(o_Head_y),    32'(my[0]));
        check_eq({tag, "_way"}, 32'(o_Way),       32'(mway));
        check_eq({tag, "_len"}, 32'(o_Len),       32'(mlen));
        check_eq({tag, "_go"},  32'(o_Game_Over), 32'(mgo));
    endtask

    task automatic check_q(input string tag, input int x, input int y);
        i_Q_x = 7'(x);
        i_Q_y = 7'(y);
        #1;
        check_eq(tag, 32'(o_Q_Hit), 32'(model_hit(x, y)));
    endtask

    // Predict the move, queue it, drive one tick, then wait for resolution and compare.
    task automatic move(input string tag, input int nx, input int ny, input int nw,
                        input int fx, input int fy);
        exp_t e, g;
        int   eat, lim, hit, k, eats;
        eat    = (nx == fx && ny == fy) ? 1 : 0;
        e.eats = 0;
        e.busy0 = 1;
        if (nx >= 48 || ny >= 64) begin
            e.go = 1; e.lat = 0; e.busy0 = 0; mgo = 1;
        end else begin
            lim = (eat == 1 || mlen == 16) ? mlen : mlen - 1;
            hit = -1;
            for (int m = 0; m < lim; m++) begin
                if (hit < 0 && mx[m] == nx && my[m] == ny) hit = m;
            end
            if (hit >= 0) begin
                e.go = 1; e.lat = hit + 1; mgo = 1;
            end else begin
                for (int j = 15; j > 0; j--) begin
                    mx[j] = mx[j-1];
                    my[j] = my[j-1];
                end
                mx[0] = nx; my[0] = ny; mway = nw;
                if (eat == 1) begin
                    if (mlen < 16) mlen++;
                    e.eats = 1;
                end
                e.go = 0; e.lat = lim + 1;
            end
        end
        e.hx = mx[0]; e.hy = my[0]; e.way = mway; e.len = mlen;
        sb.push_back(e);

        @(negedge i_Clk);
        i_Next_x = 7'(nx); i_Next_y = 7'(ny); i_Next_Way = 2'(nw);
        i_Food_x = 7'(fx); i_Food_y = 7'(fy);
        i_Tick = 1'b1;
        @(negedge i_Clk);
        i_Tick = 1'b0;
        k = 0;
        eats = 0;
        g = sb.pop_front();
        check_eq({tag, "_busy0"}, 32'(o_Busy), 32'(g.busy0));
        while (k < 40) begin
            eats += int'(o_Eat);
            if (o_Game_Over || (k > 0 && !o_Busy)) break;
            @(negedge i_Clk);
            k++;
        end
        @(negedge i_Clk);
        eats += int'(o_Eat);
        check_eq({tag, "_lat"},  32'(k),           32'(g.lat));
        check_eq({tag, "_go"},   32'(o_Game_Over), 32'(g.go));
        check_eq({tag, "_hx"},   32'(o_Head_x),    32'(g.hx));
        check_eq({tag, "_hy"},   32'(o_Head_y),    32'(g.hy));
        check_eq({tag, "_way"},  32'(o_Way),       32'(g.way));
        check_eq({tag, "_len"},  32'(o_Len),       32'(g.len));
        check_eq({tag, "_eat"},  32'(eats),        32'(g.eats));
    endtask

    task automatic ignored_tick(input string tag);
        @(negedge i_Clk);
        i_Tick = 1'b1;
        @(negedge i_Clk);
        i_Tick = 1'b0;
        repeat (3) @(negedge i_Clk);
        check_eq({tag, "_busy"}, 32'(o_Busy), 32'd0);
        check_state(tag);
    endtask

    task automatic restart(input string tag);
        @(negedge i_Clk);
        i_Restart = 1'b1;
        @(negedge i_Clk);
        i_Restart = 1'b0;
        model_reset();
        check_state(tag);
        check_eq({tag, "_busy"}, 32'(o_Busy), 32'd0);
    endtask

    initial begin
        i_Rst = 1'b0; i_Tick = 1'b0; i_Restart = 1'b0;
        i_Next_x = 7'd0; i_Next_y = 7'd0; i_Next_Way = 2'd0;
        i_Food_x = 7'd40; i_Food_y = 7'd60; i_Q_x = 7'd0; i_Q_y = 7'd0;
        model_reset();
        #23 i_Rst = 1'b1;
        @(negedge i_Clk);

        check_state("rst");
        check_eq("rst_busy", 32'(o_Busy), 32'd0);
        check_eq("rst_eat",  32'(o_Eat),  32'd0);
        check_q("q_rst_body", 24, 31);
        check_eq("q_rst_body_abs", 32'(o_Q_Hit), 32'd1);
        check_q("q_rst_far", 24, 35);
        check_q("q_rst_beyond_len", 24, 29);

        move("step", 24, 33, 2, 40, 60);
        check_q("q_old_tail", 24, 30);
        check_q("q_mid", 24, 31);

        move("eat1", 24, 34, 2, 24, 34);
        move("eat2", 24, 35, 2, 24, 35);

        @(negedge i_Clk);
        i_Restart = 1'b1;
        @(negedge i_Clk);
        i_Restart = 1'b0;
        check_state("restart_in_run");

        move("tail_ok", 24, 31, 3, 40, 60);
        move("tail_eat", 24, 32, 0, 24, 32);
        ignored_tick("go_tick1");
        restart("restart1");

        move("tele", 0, 10, 0, 40, 60);
        move("wall_x", 127, 10, 0, 40, 60);
        ignored_tick("go_tick2");
        restart("restart2");
        move("wall_y", 24, 64, 2, 40, 60);
        restart("restart3");

        for (int y = 33; y <= 46; y++) begin
            move("grow", 24, y, 2, 24, y);
        end
        move("full_step", 24, 47, 2, 40, 60);
        check_q("q_full_tail", 24, 32);

        @(negedge i_Clk);
        i_Next_x = 7'd24; i_Next_y = 7'd48; i_Next_Way = 2'd2;
        i_Tick = 1'b1;
        @(negedge i_Clk);
        i_Tick = 1'b0;
        check_eq("mid_busy", 32'(o_Busy), 32'd1);
        i_Next_y = 7'd49;
        i_Tick = 1'b1;
        @(negedge i_Clk);
        i_Tick = 1'b0;
        check_eq("mid_busy2", 32'(o_Busy), 32'd1);
        check_eq("mid_hy", 32'(o_Head_y), 32'(my[0]));
        #2 i_Rst = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        check_eq("async_rst_busy", 32'(o_Busy), 32'd0);
        @(negedge i_Clk);
        #1 i_Rst = 1'b1;
        repeat (20) @(negedge i_Clk);
        check_state("post_rst");
        check_eq("post_rst_busy", 32'(o_Busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
